// File: rtl/booth_pkg.sv
// Shared types and sizing for the radix-2 Booth multiplier.
package booth_pkg;

    localparam int unsigned W      = 4;
    localparam int unsigned PW     = 2 * W;
    localparam int unsigned N_ITER = 4;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Q_1}.
    function automatic booth_op_t booth_select(input logic q0, input logic q_m1);
        booth_op_t op;
        case ({q0, q_m1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/adder_subtractor4.sv
// 4-bit adder/subtractor: Result = A + B when S=0, A - B when S=1.
module adder_subtractor4
    import booth_pkg::*;
(
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         S,
    output logic [W-1:0] Result,
    output logic         CarryOut
);

    logic [W:0] sum_c;

    // Two's-complement subtract as A + ~B + 1; carry out is the raw bit W.
    always_comb begin
        sum_c    = {1'b0, A} + {1'b0, B ^ {W{S}}} + (W+1)'(S);
        Result   = sum_c[W-1:0];
        CarryOut = sum_c[W];
    end

endmodule

// File: rtl/booth_multiplier4.sv
// Sequential 4x4 signed multiplier, radix-2 Booth, four iteration cycles.
module booth_multiplier4
    import booth_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  multiplicand,
    input  logic [W-1:0]  multiplier,
    output logic [PW-1:0] product,
    output logic          busy,
    output logic          done
);

    state_t           state, state_nxt;
    logic [W-1:0]     acc, acc_nxt;
    logic [W-1:0]     q_reg, q_nxt;
    logic             q_1, q_1_nxt;
    logic [W-1:0]     m_reg, m_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PW-1:0]    product_nxt;
    logic             busy_nxt, done_nxt;

    booth_op_t        op_c;
    logic             add_s_c;
    logic [W-1:0]     sum_c;
    logic             carry_c;
    logic [W-1:0]     r_c;
    logic             sgn_c;

    adder_subtractor4 u_addsub (
        .A        (acc),
        .B        (m_reg),
        .S        (add_s_c),
        .Result   (sum_c),
        .CarryOut (carry_c)
    );

    // Booth select and true sign of the 5-bit result (handles M = -8 overflow).
    always_comb begin
        op_c    = booth_select(q_reg[0], q_1);
        add_s_c = (op_c == OP_SUB);
        if (op_c == OP_NONE) begin
            r_c   = acc;
            sgn_c = acc[W-1];
        end else begin
            r_c   = sum_c;
            sgn_c = acc[W-1] ^ (m_reg[W-1] ^ add_s_c) ^ carry_c;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            m_reg   <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            q_reg   <= q_nxt;
            q_1     <= q_1_nxt;
            m_reg   <= m_nxt;
            cnt     <= cnt_nxt;
            product <= product_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state, iteration shift and output decode.
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        q_nxt       = q_reg;
        q_1_nxt     = q_1;
        m_nxt       = m_reg;
        cnt_nxt     = cnt;
        product_nxt = product;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    acc_nxt   = '0;
                    q_nxt     = multiplier;
                    q_1_nxt   = 1'b0;
                    m_nxt     = multiplicand;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                acc_nxt = {sgn_c, r_c[W-1:1]};
                q_nxt   = {r_c[0], q_reg[W-1:1]};
                q_1_nxt = q_reg[0];
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(N_ITER - 1)) begin
                    state_nxt   = DONE;
                    product_nxt = {sgn_c, r_c[W-1:1], r_c[0], q_reg[W-1:1]};
                    done_nxt    = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_multiplier4.sv
// Self-checking bench for booth_multiplier4.
module tb_booth_multiplier4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic [7:0] product;
    logic       busy;
    logic       done;

    int checks;
    int failures;
    logic prev_done;

    booth_multiplier4 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] exp;
        string      name;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed multiplication of the two 4-bit operands.
    function automatic logic [7:0] ref_mul(input logic [3:0] m, input logic [3:0] q);
        int a;
        int b;
        a = int'($signed(m));
        b = int'($signed(q));
        return 8'(a * b);
    endfunction

    // done must never stay high two samples in a row.
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (prev_done) begin
                failures++;
                $display("FAIL done_width: got 2 consecutive cycles expected 1");
            end
        end
        prev_done <= done;
    end

    // One full operation with latency, busy and product checks.
    task automatic do_op(input logic [3:0] m, input logic [3:0] q, input string tag);
        logic [7:0] prev;
        int lat;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        prev         = product;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 4'($urandom);
        multiplier   = 4'($urandom);
        check({tag, "_busy_at_accept"}, int'(busy), 1);
        check({tag, "_product_held_at_accept"}, int'(product), int'(prev));
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) begin
                failures++;
                checks++;
                $display("FAIL %s_busy_dropped: got 0 expected 1 at cycle %0d", tag, i);
                break;
            end
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_product"}, int'(product), int'(ref_mul(m, q)));
        check({tag, "_busy_at_done"}, int'(busy), 1);
        @(posedge clk);
        #1;
        check({tag, "_done_cleared"}, int'(done), 0);
        check({tag, "_busy_cleared"}, int'(busy), 0);
        check({tag, "_product_stable"}, int'(product), int'(ref_mul(m, q)));
    endtask

    initial begin
        vec_t vecs[5];
        int   ndone;
        logic [7:0] hold;

        checks       = 0;
        failures     = 0;
        prev_done    = 1'b0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = 4'h0;
        multiplier   = 4'h0;

        vecs[0] = '{m: 4'h3, q: 4'h2, exp: 8'h06, name: "pos_pos"};
        vecs[1] = '{m: 4'hD, q: 4'h5, exp: 8'hF1, name: "neg_pos"};
        vecs[2] = '{m: 4'h8, q: 4'h8, exp: 8'h40, name: "min_min"};
        vecs[3] = '{m: 4'h7, q: 4'h8, exp: 8'hC8, name: "max_min"};
        vecs[4] = '{m: 4'h0, q: 4'hF, exp: 8'h00, name: "zero"};

        repeat (2) @(posedge clk);
        #1;
        check("reset_product", int'(product), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table with hand-derived expectations.
        foreach (vecs[i]) begin
            do_op(vecs[i].m, vecs[i].q, vecs[i].name);
            check({vecs[i].name, "_table"}, int'(product), int'(vecs[i].exp));
        end

        // Exhaustive sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(4'(a), 4'(b), "sweep");
            end
        end

        // Random operands.
        for (int n = 0; n < 40; n++) begin
            do_op(4'($urandom), 4'($urandom), "rand");
        end

        // Operands and start pulsed mid-RUN must be ignored.
        @(negedge clk);
        multiplicand = 4'h2;
        multiplier   = 4'h3;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        multiplicand = 4'h7;
        multiplier   = 4'h7;
        start        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrun_ignored_count", ndone, 1);
        check("midrun_ignored_product", int'(product), 8'h06);
        check("midrun_idle_after", int'(busy), 0);

        // start held for 8 cycles gives back-to-back operations, no queueing.
        @(negedge clk);
        multiplicand = 4'h3;
        multiplier   = 4'h3;
        start        = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 7) start = 1'b0;
            if (done) ndone++;
        end
        check("held_start_ops", ndone, 2);
        check("held_start_product", int'(product), 8'h09);
        check("held_start_idle", int'(busy), 0);

        // Reset in the middle of an operation.
        @(negedge clk);
        multiplicand = 4'h5;
        multiplier   = 4'h3;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rst_mid_no_done", ndone, 0);
        check("rst_mid_product_after", int'(product), 0);
        do_op(4'h5, 4'h3, "after_reset");
        hold = product;
        check("after_reset_value", int'(hold), 8'h0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
